// File: rtl/rggen_bit_field_w01s_ws_wos_hwset.sv
// Set-type register bit field (W0S/W1S/WS) with a hardware set path, edge detection,
// selectable set/clear priority, per-bit lost-event flags and a registered interrupt.
module rggen_bit_field_w01s_ws_wos_hwset #(
    parameter logic [1:0]       SET_VALUE      = 2'b00,
    parameter bit               WRITE_ONLY     = 1'b0,
    parameter int unsigned      WIDTH          = 8,
    parameter logic [WIDTH-1:0] INITIAL_VALUE  = {WIDTH{1'b0}},
    parameter logic [1:0]       HW_SET_MODE    = 2'b00,
    parameter bit               CLEAR_PRIORITY = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_bit_field_valid,
    input  logic [WIDTH-1:0] i_bit_field_read_mask,
    input  logic [WIDTH-1:0] i_bit_field_write_mask,
    input  logic [WIDTH-1:0] i_bit_field_write_data,
    output logic [WIDTH-1:0] o_bit_field_read_data,
    output logic [WIDTH-1:0] o_bit_field_value,
    input  logic [WIDTH-1:0] i_set,
    input  logic [WIDTH-1:0] i_clear,
    input  logic [WIDTH-1:0] i_enable,
    output logic [WIDTH-1:0] o_value,
    output logic [WIDTH-1:0] o_overflow,
    output logic             o_irq
);

    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] set_dly_q, set_dly_d;
    logic [WIDTH-1:0] overflow_q, overflow_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] sw_set;
    logic [WIDTH-1:0] hw_set;
    logic [WIDTH-1:0] set_all;

    // Read mask carries no meaning for a set-type field.
    logic unused_read_mask;
    assign unused_read_mask = ^i_bit_field_read_mask;

    always_comb begin
        sw_set = '0;
        if (i_bit_field_valid && (|i_bit_field_write_mask)) begin
            case (SET_VALUE)
                2'b00:   sw_set = i_bit_field_write_mask & ~i_bit_field_write_data;
                2'b01:   sw_set = i_bit_field_write_mask & i_bit_field_write_data;
                default: sw_set = '1;
            endcase
        end
    end

    always_comb begin
        hw_set = '0;
        case (HW_SET_MODE)
            2'b00:   hw_set = i_set;
            2'b01:   hw_set = i_set & ~set_dly_q;
            2'b10:   hw_set = ~i_set & set_dly_q;
            default: hw_set = i_set ^ set_dly_q;
        endcase
    end

    always_comb begin
        set_all   = sw_set | hw_set;
        set_dly_d = i_set;
        if (CLEAR_PRIORITY) begin
            value_d = (value_q | set_all) & ~i_clear;
        end else begin
            value_d = (value_q & ~i_clear) | set_all;
        end
        // Only hardware events landing on an already-set bit count as lost.
        overflow_d = (overflow_q & ~i_clear) | (hw_set & value_q & ~i_clear);
        irq_d      = |(value_q & i_enable);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            value_q    <= INITIAL_VALUE;
            set_dly_q  <= '0;
            overflow_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            value_q    <= value_d;
            set_dly_q  <= set_dly_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    assign o_value               = value_q;
    assign o_bit_field_value     = value_q;
    assign o_bit_field_read_data = WRITE_ONLY ? '0 : value_q;
    assign o_overflow            = overflow_q;
    assign o_irq                 = irq_q;

endmodule

// File: tb/tb_rggen_bit_field_w01s_ws_wos_hwset.sv
// Bench for rggen_bit_field_w01s_ws_wos_hwset: four differently configured fields share
// one stimulus stream and are checked against a per-bit behavioural model every cycle.
`timescale 1ns/1ps
module tb_rggen_bit_field_w01s_ws_wos_hwset;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] rmask = 8'h00;
    logic [7:0] wmask = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] set_in = 8'h00;
    logic [7:0] clr = 8'h00;
    logic [7:0] en = 8'h00;

    logic [7:0] d_val[NI];
    logic [7:0] d_bfv[NI];
    logic [7:0] d_rd[NI];
    logic [7:0] d_ovf[NI];
    logic       d_irq[NI];

    int n_pass = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    // Instance configurations: SET_VALUE, HW_SET_MODE, CLEAR_PRIORITY, WRITE_ONLY, INITIAL_VALUE
    function automatic logic [1:0] cfg_setv(input int k);
        case (k) 0: return 2'b01; 1: return 2'b00; 2: return 2'b10; default: return 2'b11; endcase
    endfunction
    function automatic logic [1:0] cfg_hwm(input int k);
        case (k) 0: return 2'b01; 1: return 2'b00; 2: return 2'b10; default: return 2'b11; endcase
    endfunction
    function automatic logic cfg_cp(input int k);
        return (k == 1 || k == 3);
    endfunction
    function automatic logic cfg_wo(input int k);
        return (k == 2);
    endfunction
    function automatic logic [7:0] cfg_init(input int k);
        case (k) 0: return 8'h81; 3: return 8'h3C; default: return 8'h00; endcase
    endfunction

    rggen_bit_field_w01s_ws_wos_hwset #(
        .SET_VALUE(2'b01), .WRITE_ONLY(1'b0), .WIDTH(8), .INITIAL_VALUE(8'h81),
        .HW_SET_MODE(2'b01), .CLEAR_PRIORITY(1'b0)
    ) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_bit_field_valid(valid),
        .i_bit_field_read_mask(rmask), .i_bit_field_write_mask(wmask),
        .i_bit_field_write_data(wdata), .o_bit_field_read_data(d_rd[0]),
        .o_bit_field_value(d_bfv[0]), .i_set(set_in), .i_clear(clr), .i_enable(en),
        .o_value(d_val[0]), .o_overflow(d_ovf[0]), .o_irq(d_irq[0])
    );
    rggen_bit_field_w01s_ws_wos_hwset #(
        .SET_VALUE(2'b00), .WRITE_ONLY(1'b0), .WIDTH(8), .INITIAL_VALUE(8'h00),
        .HW_SET_MODE(2'b00), .CLEAR_PRIORITY(1'b1)
    ) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_bit_field_valid(valid),
        .i_bit_field_read_mask(rmask), .i_bit_field_write_mask(wmask),
        .i_bit_field_write_data(wdata), .o_bit_field_read_data(d_rd[1]),
        .o_bit_field_value(d_bfv[1]), .i_set(set_in), .i_clear(clr), .i_enable(en),
        .o_value(d_val[1]), .o_overflow(d_ovf[1]), .o_irq(d_irq[1])
    );
    rggen_bit_field_w01s_ws_wos_hwset #(
        .SET_VALUE(2'b10), .WRITE_ONLY(1'b1), .WIDTH(8), .INITIAL_VALUE(8'h00),
        .HW_SET_MODE(2'b10), .CLEAR_PRIORITY(1'b0)
    ) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_bit_field_valid(valid),
        .i_bit_field_read_mask(rmask), .i_bit_field_write_mask(wmask),
        .i_bit_field_write_data(wdata), .o_bit_field_read_data(d_rd[2]),
        .o_bit_field_value(d_bfv[2]), .i_set(set_in), .i_clear(clr), .i_enable(en),
        .o_value(d_val[2]), .o_overflow(d_ovf[2]), .o_irq(d_irq[2])
    );
    rggen_bit_field_w01s_ws_wos_hwset #(
        .SET_VALUE(2'b11), .WRITE_ONLY(1'b0), .WIDTH(8), .INITIAL_VALUE(8'h3C),
        .HW_SET_MODE(2'b11), .CLEAR_PRIORITY(1'b1)
    ) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_bit_field_valid(valid),
        .i_bit_field_read_mask(rmask), .i_bit_field_write_mask(wmask),
        .i_bit_field_write_data(wdata), .o_bit_field_read_data(d_rd[3]),
        .o_bit_field_value(d_bfv[3]), .i_set(set_in), .i_clear(clr), .i_enable(en),
        .o_value(d_val[3]), .o_overflow(d_ovf[3]), .o_irq(d_irq[3])
    );

    // Behavioural model, one bit at a time.
    logic [7:0] m_val[NI];
    logic [7:0] m_prev[NI];
    logic [7:0] m_ovf[NI];
    logic       m_irq[NI];

    always @(posedge clk or negedge rst_n) begin : model
        logic [7:0] nv;
        logic [7:0] no;
        logic       sw, hw, ev, c;
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                m_val[k]  <= cfg_init(k);
                m_prev[k] <= 8'h00;
                m_ovf[k]  <= 8'h00;
                m_irq[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                nv = m_val[k];
                no = m_ovf[k];
                for (int b = 0; b < 8; b++) begin
                    sw = 1'b0;
                    if (valid && wmask != 8'h00) begin
                        if (cfg_setv(k) == 2'b00)      sw = wmask[b] && !wdata[b];
                        else if (cfg_setv(k) == 2'b01) sw = wmask[b] && wdata[b];
                        else                           sw = 1'b1;
                    end
                    if (cfg_hwm(k) == 2'b00)      hw = set_in[b];
                    else if (cfg_hwm(k) == 2'b01) hw = set_in[b] && !m_prev[k][b];
                    else if (cfg_hwm(k) == 2'b10) hw = !set_in[b] && m_prev[k][b];
                    else                          hw = set_in[b] != m_prev[k][b];
                    ev = sw || hw;
                    c  = clr[b];
                    if (ev && c)  nv[b] = !cfg_cp(k);
                    else if (c)   nv[b] = 1'b0;
                    else if (ev)  nv[b] = 1'b1;
                    if (c)                      no[b] = 1'b0;
                    else if (hw && m_val[k][b]) no[b] = 1'b1;
                end
                m_val[k]  <= nv;
                m_ovf[k]  <= no;
                m_prev[k] <= set_in;
                m_irq[k]  <= (m_val[k] & en) != 8'h00;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            check($sformatf("u%0d o_value", k), d_val[k], m_val[k]);
            check($sformatf("u%0d o_bit_field_value", k), d_bfv[k], m_val[k]);
            check($sformatf("u%0d read_data", k), d_rd[k], cfg_wo(k) ? 8'h00 : m_val[k]);
            check($sformatf("u%0d o_overflow", k), d_ovf[k], m_ovf[k]);
            check($sformatf("u%0d o_irq", k), {7'b0, d_irq[k]}, {7'b0, m_irq[k]});
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset u0 value", d_val[0], 8'h81);
        check("reset u3 value", d_val[3], 8'h3C);
        check("reset u0 rdata", d_rd[0], 8'h81);
        check("reset u2 rdata wo", d_rd[2], 8'h00);
        check("reset u0 irq", {7'b0, d_irq[0]}, 8'h00);
        rst_n = 1'b1;
        step();

        clr = 8'hFF; step(); clr = 8'h00;
        check("clear u0 value", d_val[0], 8'h00);

        // Software write: mask 0F, data 05
        valid = 1'b1; wmask = 8'h0F; wdata = 8'h05; step();
        valid = 1'b0;
        check("w1s value", d_val[0], 8'h05);
        check("w0s value", d_val[1], 8'h0A);
        check("ws value", d_val[2], 8'hFF);
        check("ws rdata wo", d_rd[2], 8'h00);
        check("ws both value", d_val[3], 8'hFF);
        wmask = 8'hFF; wdata = 8'h00; step();
        check("no valid u1", d_val[1], 8'h0A);
        check("no valid u0", d_val[0], 8'h05);
        wmask = 8'h00;
        clr = 8'hFF; step(); clr = 8'h00;

        // Hold i_set[3] high for three cycles
        set_in = 8'h08; step();
        check("rise set u0", d_val[0], 8'h08);
        check("level set u1", d_val[1], 8'h08);
        check("fall none u2", d_val[2], 8'h00);
        check("level ovf c1", d_ovf[1], 8'h00);
        step();
        check("level ovf c2", d_ovf[1], 8'h08);
        check("rise ovf c2", d_ovf[0], 8'h00);
        step();
        check("fall none c3", d_val[2], 8'h00);
        set_in = 8'h00; step();
        check("fall set u2", d_val[2], 8'h08);
        check("both ovf u3", d_ovf[3], 8'h08);
        check("rise ovf end", d_ovf[0], 8'h00);

        // Clear with a simultaneous hardware event
        clr = 8'h08; set_in = 8'h08; step();
        check("ovf clr u1 value", d_val[1], 8'h00);
        check("ovf clr u1 ovf", d_ovf[1], 8'h00);
        check("set wins u0", d_val[0], 8'h08);
        check("no reraise u0", d_ovf[0], 8'h00);
        clr = 8'h00; set_in = 8'h00; step();
        clr = 8'hFF; step(); clr = 8'h00;

        // Set and clear on bit 0 together
        set_in = 8'h01; clr = 8'h01; step();
        check("prio set u0", d_val[0], 8'h01);
        check("prio clr u1", d_val[1], 8'h00);
        check("prio clr u3", d_val[3], 8'h00);
        check("prio ovf u1", d_ovf[1], 8'h00);
        set_in = 8'h00; clr = 8'h00; step();
        clr = 8'hFF; step(); clr = 8'h00;

        // Interrupt latency
        en = 8'h10; valid = 1'b1; wmask = 8'h10; wdata = 8'h10; step();
        valid = 1'b0; wmask = 8'h00;
        check("irq val N+1", d_val[0], 8'h10);
        check("irq N+1", {7'b0, d_irq[0]}, 8'h00);
        step();
        check("irq N+2", {7'b0, d_irq[0]}, 8'h01);
        check("irq u1 idle", {7'b0, d_irq[1]}, 8'h00);
        en = 8'h00; step();
        check("irq drop", {7'b0, d_irq[0]}, 8'h00);

        // Reset in the middle of activity
        en = 8'hFF; set_in = 8'h02; step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst u0 value", d_val[0], 8'h81);
        check("midrst u0 ovf", d_ovf[0], 8'h00);
        check("midrst u0 irq", {7'b0, d_irq[0]}, 8'h00);
        check("midrst u3 value", d_val[3], 8'h3C);
        @(negedge clk);
        rst_n = 1'b1; en = 8'h00;
        step();
        set_in = 8'h00;

        for (int i = 0; i < 200; i++) begin
            valid  = ($urandom_range(0, 3) == 0);
            wmask  = 8'($urandom);
            wdata  = 8'($urandom);
            set_in = 8'($urandom & $urandom);
            clr    = 8'($urandom & $urandom & $urandom);
            en     = 8'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rggen_bit_field_w01s_ws_wos_hwset.md
# rggen_bit_field_w01s_ws_wos_hwset

Set-type register bit field (write-0-set / write-1-set / write-any-set), extended with a hardware set path, programmable edge detection, selectable set/clear priority, per-bit lost-event (overflow) flags and a registered interrupt output. It sits between the register-block bus decode (`i_bit_field_*`) and user logic, which sets bits via events and clears them via `i_clear`. The typical use is an interrupt status register, where software or hardware events set bits and the handler clears them.

## Interface
- `SET_VALUE`, 2'b00: software set mode.
  - 00: W0S, set where mask=1 and data=0.
  - 01: W1S, set where mask=1 and data=1.
  - 1x: WS, any valid write with a nonzero mask sets all bits.
- `WRITE_ONLY`, 1'b0: 1 forces read data to 0.
- `WIDTH`, 8: field width, 1..64.
- `INITIAL_VALUE`, {WIDTH{1'b0}}: reset value of the field.
- `HW_SET_MODE`, 2'b00: hardware set detection.
  - 00: level.
  - 01: rising edge.
  - 10: falling edge.
  - 11: both edges.
- `CLEAR_PRIORITY`, 1'b0: 1 means clear wins over a simultaneous set on the same bit; 0 means set wins.
- `i_clk` input 1: clock, rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_bit_field_valid` input 1: bus access strobe for this field.
- `i_bit_field_read_mask` input WIDTH: unused, kept for interface uniformity.
- `i_bit_field_write_mask` input WIDTH: per-bit write enable.
- `i_bit_field_write_data` input WIDTH: write data.
- `o_bit_field_read_data` output WIDTH: WRITE_ONLY ? 0 : value.
- `o_bit_field_value` output WIDTH: current value.
- `i_set` input WIDTH: hardware set request, per bit.
- `i_clear` input WIDTH: hardware clear, per bit.
- `i_enable` input WIDTH: interrupt enable mask.
- `o_value` output WIDTH: current value.
- `o_overflow` output WIDTH: lost-event flag, per bit.
- `o_irq` output 1: registered OR of enabled set bits.

## Operation
- State registers:
  - `value`: reset to INITIAL_VALUE.
  - `set_d`: previous `i_set`, reset to 0.
  - `overflow`: reset to 0.
  - `irq`: reset to 0.
- Software set `sw` is 0 unless valid && |write_mask. When that holds:
  - 00: `sw` = mask & ~data.
  - 01: `sw` = mask & data.
  - 1x: `sw` = all ones.
- Hardware event `hw`, evaluated per bit:
  - level: `i_set`.
  - rising: `i_set` & ~`set_d`.
  - falling: ~`i_set` & `set_d`.
  - both: `i_set` ^ `set_d`.
- `set` = `sw` | `hw`.
- Value update:
  - CLEAR_PRIORITY=0: next value = (value & ~clear) | set.
  - CLEAR_PRIORITY=1: next value = (value | set) & ~clear.
- Overflow update: next overflow = (overflow & ~clear) | (hw & value & ~clear).
  - An overflow records a hardware event arriving on a bit that is already 1 and not being cleared in that cycle.
  - Software sets never raise overflow.
- Interrupt: next irq = |(value & i_enable), using the current, pre-update value.
- Bit independence: all operations are per bit, with no carry or interaction between bits.
- Bus reads have no side effects.

## Timing
- Reset: asynchronous assert, synchronous-to-clock release.
- Outputs during reset:
  - `o_value` = `o_bit_field_value` = INITIAL_VALUE.
  - `o_bit_field_read_data` = INITIAL_VALUE, or 0 when WRITE_ONLY=1.
  - `o_overflow` = 0.
  - `o_irq` = 0.
- Set/clear latency: 1 cycle from an edge sampling set/clear to `o_value` changing.
- Edge detection: 1 cycle, because `set_d` samples `i_set` every cycle.
  - Because `set_d` resets to 0, an `i_set` bit held high through reset release produces one rising event on the first clock in rising or both mode.
- Interrupt latency: `o_irq` lags `o_value`/`i_enable` by 1 cycle (2 cycles from the set request).
- Reset mid-operation: all state returns to reset values immediately; pending edges are lost.
- Simultaneous set and clear on a bit:
  - The result follows CLEAR_PRIORITY.
  - Overflow is not raised, because clear masks it.

## Test plan
- Reset: WIDTH=8, INITIAL_VALUE=8'h81, WRITE_ONLY=0. Assert `i_rst_n`=0 mid-run → `o_value`=8'h81, `o_overflow`=0 and `o_irq`=0 immediately.
- Software modes: SET_VALUE=01, write mask 8'h0F, data 8'h05 → value 8'h05. SET_VALUE=00, same write → value 8'h0A. SET_VALUE=10 → 8'hFF. With valid=0 → no change.
- Edge modes: HW_SET_MODE=01, `i_set[3]` held high for 3 cycles → bit 3 set once, no overflow. HW_SET_MODE=00, the same stimulus → `o_overflow[3]`=1 on the second cycle. HW_SET_MODE=10 → bit 3 set on the falling edge only.
- Priority: value 0, `i_set[0]`=1 and `i_clear[0]`=1 in the same cycle → value bit 0 = 1 when CLEAR_PRIORITY=0, 0 when CLEAR_PRIORITY=1. Overflow stays 0 in both cases.
- Overflow clear: `o_overflow[2]`=1, pulse `i_clear[2]` → value[2]=0 and overflow[2]=0 next cycle. A hardware event in the same cycle as the clear does not re-raise overflow.
- IRQ: `i_enable`=8'h10, set bit 4 via W1S at cycle N → `o_value[4]`=1 at N+1 and `o_irq`=1 at N+2. Drop `i_enable` → `o_irq`=0 one cycle later. WRITE_ONLY=1 → read data 0 throughout.
